// File: rtl/avalon_st_pkt_arbiter.sv
// Packet-atomic round-robin arbiter sharing one Avalon-ST path between sources.
// Ports: clk/rst, per-source in_* bundles, registered out_* stage, grant_idx/busy, sticky err_*.
module avalon_st_pkt_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC*DATA_W-1:0]    in_data,
    input  logic [NUM_SRC-1:0]           in_valid,
    output logic [NUM_SRC-1:0]           in_ready,
    input  logic [NUM_SRC-1:0]           in_sop,
    input  logic [NUM_SRC-1:0]           in_eop,
    input  logic [NUM_SRC*EMPTY_W-1:0]   in_empty,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic [EMPTY_W-1:0]           out_empty,
    output logic [$clog2(NUM_SRC)-1:0]   grant_idx,
    output logic                         busy,
    output logic                         err_no_sop,
    output logic                         err_sop
);

    localparam int IDX_W = $clog2(NUM_SRC);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic                 first_q, first_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_sop_q, out_sop_d;
    logic                 out_eop_q, out_eop_d;
    logic [EMPTY_W-1:0]   out_empty_q, out_empty_d;
    logic                 err_no_sop_q, err_no_sop_d;
    logic                 err_sop_q, err_sop_d;

    logic                 found;
    logic [IDX_W-1:0]     pick;
    logic [IDX_W-1:0]     cand;
    logic                 stage_free;
    logic                 accept;
    logic [DATA_W-1:0]    g_data;
    logic                 g_sop;
    logic                 g_eop;
    logic [EMPTY_W-1:0]   g_empty;

    // First valid source at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_SRC);
            if (!found && in_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        g_data  = in_data[int'(grant_q)*DATA_W +: DATA_W];
        g_empty = in_empty[int'(grant_q)*EMPTY_W +: EMPTY_W];
        g_sop   = in_sop[grant_q];
        g_eop   = in_eop[grant_q];
    end

    assign stage_free = !out_valid_q || out_ready;

    always_comb begin
        in_ready = '0;
        if (state_q == LOCKED && stage_free) begin
            in_ready[grant_q] = 1'b1;
        end
    end

    assign accept = in_ready[grant_q] && in_valid[grant_q];

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        first_d      = first_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_sop_d    = out_sop_q;
        out_eop_d    = out_eop_q;
        out_empty_d  = out_empty_q;
        err_no_sop_d = err_no_sop_q;
        err_sop_d    = err_sop_q;

        // Drain first; a same-cycle accept refills the stage below.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = LOCKED;
                    first_d = 1'b1;
                    if (!in_sop[pick]) begin
                        err_no_sop_d = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = g_data;
                    out_sop_d   = g_sop;
                    out_eop_d   = g_eop;
                    out_empty_d = g_empty;
                    first_d     = 1'b0;
                    if (g_sop && !first_q) begin
                        err_sop_d = 1'b1;
                    end
                    if (g_eop) begin
                        state_d = IDLE;
                        if (int'(grant_q) == NUM_SRC - 1) begin
                            rr_ptr_d = '0;
                        end else begin
                            rr_ptr_d = grant_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            first_q      <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_empty_q  <= '0;
            err_no_sop_q <= 1'b0;
            err_sop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            first_q      <= first_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            out_empty_q  <= out_empty_d;
            err_no_sop_q <= err_no_sop_d;
            err_sop_q    <= err_sop_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_sop    = out_sop_q;
    assign out_eop    = out_eop_q;
    assign out_empty  = out_empty_q;
    assign grant_idx  = grant_q;
    assign busy       = (state_q == LOCKED);
    assign err_no_sop = err_no_sop_q;
    assign err_sop    = err_sop_q;

endmodule

// File: tb/tb_avalon_st_pkt_arbiter.sv
// Directed bench for avalon_st_pkt_arbiter with two sources.
// Sources replay beat tables; sink beats are captured and checked.
module tb_avalon_st_pkt_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [1:0]  in_sop;
    logic [1:0]  in_eop;
    logic [3:0]  in_empty;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic [1:0]  out_empty;
    logic        grant_idx;
    logic        busy;
    logic        err_no_sop;
    logic        err_sop;

    always #5 clk = ~clk;

    avalon_st_pkt_arbiter #(.NUM_SRC(2), .DATA_W(32), .EMPTY_W(2)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
        .grant_idx(grant_idx), .busy(busy),
        .err_no_sop(err_no_sop), .err_sop(err_sop)
    );

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
        logic        grant;
    } cap_t;

    cap_t        cap[$];
    logic [31:0] src_data  [2][32];
    logic        src_sop   [2][32];
    logic        src_eop   [2][32];
    logic [1:0]  src_empty [2][32];
    int          src_len [2];
    int          src_idx [2];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_beat(input int s, input logic [31:0] d, input logic sp,
                            input logic ep, input logic [1:0] em);
        src_data[s][src_len[s]]  = d;
        src_sop[s][src_len[s]]   = sp;
        src_eop[s][src_len[s]]   = ep;
        src_empty[s][src_len[s]] = em;
        src_len[s]++;
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if (src_idx[i] < src_len[i]) begin
                in_valid[i]         = 1'b1;
                in_data[i*32 +: 32] = src_data[i][src_idx[i]];
                in_sop[i]           = src_sop[i][src_idx[i]];
                in_eop[i]           = src_eop[i][src_idx[i]];
                in_empty[i*2 +: 2]  = src_empty[i][src_idx[i]];
            end else begin
                in_valid[i]         = 1'b0;
                in_data[i*32 +: 32] = '0;
                in_sop[i]           = 1'b0;
                in_eop[i]           = 1'b0;
                in_empty[i*2 +: 2]  = '0;
            end
        end
    endtask

    task automatic step();
        logic [1:0] fire;
        cap_t       c;
        #1;
        fire = in_valid & in_ready;
        if (out_valid && out_ready) begin
            c.data  = out_data;
            c.sop   = out_sop;
            c.eop   = out_eop;
            c.empty = out_empty;
            c.grant = grant_idx;
            cap.push_back(c);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (fire[i]) src_idx[i]++;
        end
        drive();
    endtask

    task automatic run_until_cap(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (cap.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, cap.size(), n);
    endtask

    task automatic chk_cap(input string tag, input int i, input logic [31:0] d,
                           input logic sp, input logic ep, input logic g);
        chk({tag, "_data"}, cap[i].data, d);
        chk({tag, "_sop"}, {31'd0, cap[i].sop}, {31'd0, sp});
        chk({tag, "_eop"}, {31'd0, cap[i].eop}, {31'd0, ep});
        chk({tag, "_grant"}, {31'd0, cap[i].grant}, {31'd0, g});
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        src_len   = '{0, 0};
        src_idx   = '{0, 0};
        drive();

        // Reset
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_sop_eop", {30'd0, out_sop, out_eop}, 32'd0);
        chk("rst_out_empty", {30'd0, out_empty}, 32'd0);
        chk("rst_grant", {31'd0, grant_idx}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_errs", {30'd0, err_no_sop, err_sop}, 32'd0);
        chk("rst_in_ready", {30'd0, in_ready}, 32'd0);

        // Two simultaneous 3-beat packets
        cap.delete();
        add_beat(0, 32'hA0, 1'b1, 1'b0, 2'd0);
        add_beat(0, 32'hA1, 1'b0, 1'b0, 2'd0);
        add_beat(0, 32'hA2, 1'b0, 1'b1, 2'd0);
        add_beat(1, 32'hB0, 1'b1, 1'b0, 2'd0);
        add_beat(1, 32'hB1, 1'b0, 1'b0, 2'd0);
        add_beat(1, 32'hB2, 1'b0, 1'b1, 2'd0);
        drive();
        run_until_cap(6, 40, "rr_count");
        step();
        step();
        chk("rr_no_extra", cap.size(), 6);
        if (cap.size() >= 6) begin
            chk_cap("rr_a0", 0, 32'hA0, 1'b1, 1'b0, 1'b0);
            chk_cap("rr_a1", 1, 32'hA1, 1'b0, 1'b0, 1'b0);
            chk_cap("rr_a2", 2, 32'hA2, 1'b0, 1'b1, 1'b0);
            chk_cap("rr_b0", 3, 32'hB0, 1'b1, 1'b0, 1'b1);
            chk_cap("rr_b1", 4, 32'hB1, 1'b0, 1'b0, 1'b1);
            chk_cap("rr_b2", 5, 32'hB2, 1'b0, 1'b1, 1'b1);
        end

        // Single-beat packet on src1
        cap.delete();
        add_beat(1, 32'h11, 1'b1, 1'b1, 2'd2);
        drive();
        run_until_cap(1, 20, "single_count");
        if (cap.size() >= 1) begin
            chk_cap("single", 0, 32'h11, 1'b1, 1'b1, 1'b1);
            chk("single_empty", {30'd0, cap[0].empty}, 32'd2);
        end
        chk("single_idle", {31'd0, busy}, 32'd0);
        chk("single_no_err", {30'd0, err_no_sop, err_sop}, 32'd0);

        // Backpressure mid-packet
        cap.delete();
        add_beat(0, 32'hC0, 1'b1, 1'b0, 2'd0);
        add_beat(0, 32'hC1, 1'b0, 1'b0, 2'd0);
        add_beat(0, 32'hC2, 1'b0, 1'b0, 2'd0);
        add_beat(0, 32'hC3, 1'b0, 1'b1, 2'd1);
        drive();
        run_until_cap(1, 20, "bp_first");
        out_ready = 1'b0;
        #1;
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_data", out_data, 32'hC1);
            chk("bp_in_ready", {30'd0, in_ready}, 32'd0);
        end
        chk("bp_src_idx", src_idx[0], 5);
        out_ready = 1'b1;
        run_until_cap(4, 20, "bp_count");
        step();
        step();
        chk("bp_no_extra", cap.size(), 4);
        if (cap.size() >= 4) begin
            chk_cap("bp_c0", 0, 32'hC0, 1'b1, 1'b0, 1'b0);
            chk_cap("bp_c1", 1, 32'hC1, 1'b0, 1'b0, 1'b0);
            chk_cap("bp_c2", 2, 32'hC2, 1'b0, 1'b0, 1'b0);
            chk_cap("bp_c3", 3, 32'hC3, 1'b0, 1'b1, 1'b0);
            chk("bp_c3_empty", {30'd0, cap[3].empty}, 32'd1);
        end

        // Protocol errors: no sop on first beat, sop on second beat
        cap.delete();
        add_beat(0, 32'hD0, 1'b0, 1'b0, 2'd0);
        add_beat(0, 32'hD1, 1'b1, 1'b0, 2'd0);
        add_beat(0, 32'hD2, 1'b0, 1'b1, 2'd0);
        drive();
        run_until_cap(3, 20, "err_count");
        if (cap.size() >= 3) begin
            chk_cap("err_d0", 0, 32'hD0, 1'b0, 1'b0, 1'b0);
            chk_cap("err_d1", 1, 32'hD1, 1'b1, 1'b0, 1'b0);
            chk_cap("err_d2", 2, 32'hD2, 1'b0, 1'b1, 1'b0);
        end
        chk("err_no_sop", {31'd0, err_no_sop}, 32'd1);
        chk("err_sop", {31'd0, err_sop}, 32'd1);

        // Reset mid-packet, then both sources request
        add_beat(0, 32'hE0, 1'b1, 1'b0, 2'd0);
        add_beat(0, 32'hE1, 1'b0, 1'b0, 2'd0);
        add_beat(0, 32'hE2, 1'b0, 1'b0, 2'd0);
        add_beat(0, 32'hE3, 1'b0, 1'b1, 2'd0);
        drive();
        begin
            int k;
            k = 0;
            while (src_idx[0] < 12 && k < 20) begin
                step();
                k++;
            end
        end
        chk("mid_wait", src_idx[0], 12);
        rst     = 1'b1;
        src_len = '{0, 0};
        src_idx = '{0, 0};
        drive();
        step();
        rst = 1'b0;
        #1;
        chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_grant", {31'd0, grant_idx}, 32'd0);
        chk("mid_errs", {30'd0, err_no_sop, err_sop}, 32'd0);
        cap.delete();
        add_beat(1, 32'hF0, 1'b1, 1'b0, 2'd0);
        add_beat(1, 32'hF1, 1'b0, 1'b1, 2'd3);
        add_beat(0, 32'h60, 1'b1, 1'b1, 2'd0);
        drive();
        run_until_cap(3, 30, "post_count");
        if (cap.size() >= 3) begin
            chk_cap("post_g0", 0, 32'h60, 1'b1, 1'b1, 1'b0);
            chk_cap("post_f0", 1, 32'hF0, 1'b1, 1'b0, 1'b1);
            chk_cap("post_f1", 2, 32'hF1, 1'b0, 1'b1, 1'b1);
        end
        chk("post_errs", {30'd0, err_no_sop, err_sop}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
